// File: rtl/bar_frame_scheduler.sv
// Bar-graph frame scheduler: double-buffers one frame of bar magnitudes,
// swaps banks on vblank and answers per-pixel colour lookups in 2 cycles.
//
// Stream handshake: a beat transfers on a rising clock edge where
// i_s_valid and o_s_ready are both high. o_s_ready is high only while
// filling; i_s_data/i_s_last are ignored on every other cycle.
module bar_frame_scheduler #(
   parameter int         SAMPLES   = 32,
   parameter int         WIDTH     = 32,
   parameter int         BAR_SHIFT = 4,
   parameter int         VAL_SHIFT = 0,
   parameter int         V_ACTIVE  = 480,
   parameter logic [7:0] BAR_COLOR = 8'd100
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic [WIDTH-1:0] i_s_data,
   input  logic             i_s_last,
   input  logic             i_vblank,
   input  logic             i_pix_valid,
   input  logic [9:0]       i_pix_x,
   input  logic [9:0]       i_pix_y,
   output logic             o_rgb_valid,
   output logic [7:0]       o_rgb,
   output logic             o_bank_sel,
   output logic             o_swap_pulse,
   output logic             o_frame_err,
   output logic [1:0]       o_state
);

   localparam int IW = $clog2(SAMPLES);
   localparam logic [WIDTH-1:0] LP_VACT    = WIDTH'(V_ACTIVE);
   localparam logic [WIDTH-1:0] LP_VACT_M1 = WIDTH'(V_ACTIVE - 1);
   localparam logic [IW-1:0]    LP_LAST    = IW'(SAMPLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FILL    = 2'd1,
      ST_PENDING = 2'd2,
      ST_SWAP    = 2'd3
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_wr_idx;
   logic              r_s_ready;
   logic              r_bank_sel;
   logic              r_swap_pulse;
   logic              r_frame_err;
   logic              r_vblank_q;
   logic [WIDTH-1:0]  r_bank [2][SAMPLES];

   // pixel pipeline stage 1
   logic [9:0]        r_p1_idx;
   logic [9:0]        r_p1_y;
   logic              r_p1_valid;
   logic              r_p1_sel;
   // pixel pipeline stage 2 (outputs)
   logic              r_rgb_valid;
   logic [7:0]        r_rgb;

   logic              w_beat;
   logic              w_vb_rise;
   logic              w_in_range;
   logic [IW-1:0]     w_rd_idx;
   logic [WIDTH-1:0]  w_val;
   logic [WIDTH-1:0]  w_shifted;
   logic [WIDTH-1:0]  w_height;
   logic [WIDTH-1:0]  w_dist;
   logic              w_lit;

   assign w_beat    = i_s_valid & r_s_ready;
   assign w_vb_rise = i_vblank & ~r_vblank_q;

   // Frame sequencing: fill back bank, wait for vblank edge, swap
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_wr_idx     <= '0;
         r_s_ready    <= 1'b0;
         r_bank_sel   <= 1'b0;
         r_swap_pulse <= 1'b0;
         r_frame_err  <= 1'b0;
         r_vblank_q   <= 1'b0;
      end else begin
         r_swap_pulse <= 1'b0;
         r_frame_err  <= 1'b0;
         r_vblank_q   <= i_vblank;
         case (r_state)
            ST_IDLE: begin
               r_state   <= ST_FILL;
               r_s_ready <= 1'b1;
            end
            ST_FILL: begin
               if (w_beat) begin
                  if (r_wr_idx == LP_LAST) begin
                     // full frame; a missing s_last is flagged but the frame is kept
                     r_state     <= ST_PENDING;
                     r_s_ready   <= 1'b0;
                     r_wr_idx    <= '0;
                     r_frame_err <= ~i_s_last;
                  end else if (i_s_last) begin
                     // short frame: restart, stale back-bank data gets overwritten
                     r_frame_err <= 1'b1;
                     r_wr_idx    <= '0;
                  end else begin
                     r_wr_idx <= r_wr_idx + 1'b1;
                  end
               end
            end
            ST_PENDING: begin
               if (w_vb_rise) begin
                  r_state      <= ST_SWAP;
                  r_bank_sel   <= ~r_bank_sel;
                  r_swap_pulse <= 1'b1;
               end
            end
            ST_SWAP: begin
               r_state   <= ST_FILL;
               r_s_ready <= 1'b1;
            end
            default: begin
               r_state   <= ST_IDLE;
               r_s_ready <= 1'b0;
            end
         endcase
      end
   end

   // Back-bank writes; reset clears both banks so the screen starts black
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < SAMPLES; i++) begin
               r_bank[b][i] <= '0;
            end
         end
      end else if (w_beat) begin
         r_bank[~r_bank_sel][r_wr_idx] <= i_s_data;
      end
   end

   // Stage 1: capture lookup coordinates and the front bank index
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_p1_idx   <= '0;
         r_p1_y     <= '0;
         r_p1_valid <= 1'b0;
         r_p1_sel   <= 1'b0;
      end else begin
         r_p1_idx   <= i_pix_x >> BAR_SHIFT;
         r_p1_y     <= i_pix_y;
         r_p1_valid <= i_pix_valid;
         r_p1_sel   <= r_bank_sel;
      end
   end

   // Height lookup: saturate at V_ACTIVE so the distance compare never wraps
   assign w_in_range = (r_p1_idx < 10'(SAMPLES));
   assign w_rd_idx   = r_p1_idx[IW-1:0];
   assign w_val      = r_bank[r_p1_sel][w_rd_idx];
   assign w_shifted  = w_val >> VAL_SHIFT;
   assign w_height   = (w_shifted > LP_VACT) ? LP_VACT : w_shifted;
   assign w_dist     = LP_VACT_M1 - {{(WIDTH-10){1'b0}}, r_p1_y};
   assign w_lit      = w_in_range && (r_p1_y < 10'(V_ACTIVE)) && (w_dist < w_height);

   // Stage 2: registered colour, forced to zero when not valid
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rgb_valid <= 1'b0;
         r_rgb       <= 8'd0;
      end else begin
         r_rgb_valid <= r_p1_valid;
         r_rgb       <= (r_p1_valid && w_lit) ? BAR_COLOR : 8'd0;
      end
   end

   assign o_s_ready    = r_s_ready;
   assign o_rgb_valid  = r_rgb_valid;
   assign o_rgb        = r_rgb;
   assign o_bank_sel   = r_bank_sel;
   assign o_swap_pulse = r_swap_pulse;
   assign o_frame_err  = r_frame_err;
   assign o_state      = r_state;

endmodule
